// File: rtl/pipe_hazard_unit_pkg.sv
// Shared types for the pipeline hazard/forwarding controller: forward-select
// encodings, controller FSM states and the scoreboard slot record.
package pipe_hazard_unit_pkg;

  // Scoreboard slots store addresses at this fixed width; REG_AW must not exceed it.
  localparam int unsigned MAX_REG_AW = 8;

  localparam logic [1:0] FWD_RF  = 2'd0;
  localparam logic [1:0] FWD_EX  = 2'd1;
  localparam logic [1:0] FWD_MEM = 2'd2;
  localparam logic [1:0] FWD_WB  = 2'd3;

  typedef enum logic {
    RUN,
    MEM_WAIT
  } hazState_t;

  typedef struct packed {
    logic                  valid;
    logic                  isLoad;
    logic [MAX_REG_AW-1:0] addr;
  } sbEntry_t;

  // Youngest producer wins: EX over MEM over WB.
  function automatic logic [1:0] fwdEncode(input logic exHit, input logic memHit,
                                           input logic wbHit);
    if (exHit)       return FWD_EX;
    else if (memHit) return FWD_MEM;
    else if (wbHit)  return FWD_WB;
    else             return FWD_RF;
  endfunction

endpackage

// File: rtl/pipe_hazard_unit_scoreboard.sv
// Three-slot (EX/MEM/WB) destination scoreboard with source matching and
// forward-select generation for the ID-stage operands.
module hazard_scoreboard
  import pipe_hazard_unit_pkg::*;
#(
  parameter int unsigned REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              advance,
  input  logic              bubble,
  input  logic              idWrEn,
  input  logic [REG_AW-1:0] idWrAddr,
  input  logic              idIsLoad,
  input  logic [REG_AW-1:0] idRs,
  input  logic [REG_AW-1:0] idRt,
  input  logic              idUsesRs,
  input  logic              idUsesRt,
  output logic [1:0]        fwdRsSel,
  output logic [1:0]        fwdRtSel,
  output logic              exHitRs,
  output logic              exHitRt,
  output logic              exIsLoad
);

  sbEntry_t exSlot, memSlot, wbSlot, idEntry;
  logic     memHitRs, memHitRt, wbHitRs, wbHitRt;

  function automatic logic slotHit(input sbEntry_t s, input logic [REG_AW-1:0] src,
                                   input logic uses);
    return s.valid && uses && (src != '0) && (s.addr == MAX_REG_AW'(src));
  endfunction

  always_comb begin
    idEntry        = '0;
    idEntry.valid  = idWrEn && (idWrAddr != '0) && !bubble;
    idEntry.isLoad = idIsLoad;
    idEntry.addr   = MAX_REG_AW'(idWrAddr);
  end

  always_comb begin
    exHitRs  = slotHit(exSlot,  idRs, idUsesRs);
    exHitRt  = slotHit(exSlot,  idRt, idUsesRt);
    memHitRs = slotHit(memSlot, idRs, idUsesRs);
    memHitRt = slotHit(memSlot, idRt, idUsesRt);
    wbHitRs  = slotHit(wbSlot,  idRs, idUsesRs);
    wbHitRt  = slotHit(wbSlot,  idRt, idUsesRt);
    fwdRsSel = fwdEncode(exHitRs, memHitRs, wbHitRs);
    fwdRtSel = fwdEncode(exHitRt, memHitRt, wbHitRt);
    exIsLoad = exSlot.valid && exSlot.isLoad;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exSlot  <= '0;
      memSlot <= '0;
      wbSlot  <= '0;
    end else if (advance) begin
      wbSlot  <= memSlot;
      memSlot <= exSlot;
      exSlot  <= idEntry;
    end
  end

endmodule

// File: rtl/pipe_hazard_unit.sv
// Hazard/forwarding controller: stall/flush/freeze priority, memory-wait FSM
// with sticky timeout, and saturating stall-cycle counter.
module pipe_hazard_unit
  import pipe_hazard_unit_pkg::*;
#(
  parameter int unsigned REG_AW       = 5,
  parameter int unsigned WAIT_TIMEOUT = 255,
  parameter int unsigned CNT_W        = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  input  logic              id_is_branch,
  input  logic              id_branch_taken,
  input  logic              id_wr_en,
  input  logic [REG_AW-1:0] id_wr_addr,
  input  logic              id_is_load,
  input  logic              mem_req,
  input  logic              mem_ready,
  output logic              pc_en,
  output logic              ifid_en,
  output logic              idex_en,
  output logic              exmem_en,
  output logic              memwb_en,
  output logic              ifid_flush,
  output logic              idex_flush,
  output logic [1:0]        fwd_rs_sel,
  output logic [1:0]        fwd_rt_sel,
  output logic              mem_timeout,
  output logic [CNT_W-1:0]  stall_cycles
);

  localparam int unsigned WAIT_W = $clog2(WAIT_TIMEOUT + 1);

  logic              freeze, loadUse, brStall, hazStall;
  logic              exHitRs, exHitRt, exIsLoad;
  hazState_t         state;
  logic [WAIT_W-1:0] waitCnt, waitNxt;

  hazard_scoreboard #(.REG_AW(REG_AW)) uScoreboard (
    .clk      (clk),
    .rst_n    (rst_n),
    .advance  (!freeze),
    .bubble   (idex_flush),
    .idWrEn   (id_wr_en),
    .idWrAddr (id_wr_addr),
    .idIsLoad (id_is_load),
    .idRs     (id_rs),
    .idRt     (id_rt),
    .idUsesRs (id_uses_rs),
    .idUsesRt (id_uses_rt),
    .fwdRsSel (fwd_rs_sel),
    .fwdRtSel (fwd_rt_sel),
    .exHitRs  (exHitRs),
    .exHitRt  (exHitRt),
    .exIsLoad (exIsLoad)
  );

  always_comb begin
    freeze   = mem_req && !mem_ready;
    loadUse  = (exHitRs || exHitRt) && exIsLoad;
    brStall  = id_is_branch && (exHitRs || exHitRt);
    hazStall = loadUse || brStall;
  end

  always_comb begin
    pc_en      = 1'b1;
    ifid_en    = 1'b1;
    idex_en    = 1'b1;
    exmem_en   = 1'b1;
    memwb_en   = 1'b1;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    if (freeze) begin
      pc_en    = 1'b0;
      ifid_en  = 1'b0;
      idex_en  = 1'b0;
      exmem_en = 1'b0;
      memwb_en = 1'b0;
    end else if (hazStall) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_flush = 1'b1;
    end else begin
      ifid_flush = id_branch_taken;
    end
  end

  // Counter starts at 1 on the entering cycle so it equals the number of wait cycles seen.
  always_comb begin
    waitNxt = waitCnt;
    if (state == RUN) begin
      waitNxt = freeze ? WAIT_W'(1) : '0;
    end else if (mem_ready) begin
      waitNxt = '0;
    end else if (waitCnt != WAIT_W'(WAIT_TIMEOUT)) begin
      waitNxt = waitCnt + WAIT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= RUN;
      waitCnt     <= '0;
      mem_timeout <= 1'b0;
    end else begin
      waitCnt <= waitNxt;
      if (waitNxt == WAIT_W'(WAIT_TIMEOUT)) mem_timeout <= 1'b1;
      case (state)
        RUN:      if (freeze)    state <= MEM_WAIT;
        MEM_WAIT: if (mem_ready) state <= RUN;
        default:                 state <= RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= '0;
    end else if ((freeze || hazStall) && (stall_cycles != '1)) begin
      stall_cycles <= stall_cycles + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Bench for pipe_hazard_unit: directed vector table, freeze/timeout/reset
// sequences, and randomized traffic against a producer-age reference model.
module tb_pipe_hazard_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] idRs, idRt, idWrAddr;
  logic       idUsesRs, idUsesRt, idIsBranch, idBranchTaken, idWrEn, idIsLoad;
  logic       memReq, memReady;
  logic       pcEn, ifidEn, idexEn, exmemEn, memwbEn, ifidFlush, idexFlush;
  logic [1:0] fwdRsSel, fwdRtSel;
  logic       memTimeout;
  logic [15:0] stallCycles;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_hazard_unit #(.REG_AW(5), .WAIT_TIMEOUT(8), .CNT_W(16)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .id_rs           (idRs),
    .id_rt           (idRt),
    .id_uses_rs      (idUsesRs),
    .id_uses_rt      (idUsesRt),
    .id_is_branch    (idIsBranch),
    .id_branch_taken (idBranchTaken),
    .id_wr_en        (idWrEn),
    .id_wr_addr      (idWrAddr),
    .id_is_load      (idIsLoad),
    .mem_req         (memReq),
    .mem_ready       (memReady),
    .pc_en           (pcEn),
    .ifid_en         (ifidEn),
    .idex_en         (idexEn),
    .exmem_en        (exmemEn),
    .memwb_en        (memwbEn),
    .ifid_flush      (ifidFlush),
    .idex_flush      (idexFlush),
    .fwd_rs_sel      (fwdRsSel),
    .fwd_rt_sel      (fwdRtSel),
    .mem_timeout     (memTimeout),
    .stall_cycles    (stallCycles)
  );

  typedef struct {
    logic [4:0] rs, rt;
    logic       ur, ut, br, tk, we;
    logic [4:0] wa;
    logic       ld, mq, mr;
    logic [4:0] expEn;
    logic [1:0] expFl;
    logic [1:0] expRs, expRt;
    int         expCnt;
  } vec_t;

  typedef struct {
    logic       we;
    logic [4:0] dst;
    logic       ld;
  } producer_t;

  function automatic vec_t mk(input logic [4:0] rs, input logic [4:0] rt, input logic ur,
                              input logic ut, input logic br, input logic tk, input logic we,
                              input logic [4:0] wa, input logic ld, input logic mq,
                              input logic mr, input logic [4:0] en, input logic [1:0] fl,
                              input logic [1:0] fr, input logic [1:0] ft, input int cnt);
    vec_t v;
    v.rs = rs; v.rt = rt; v.ur = ur; v.ut = ut; v.br = br; v.tk = tk; v.we = we;
    v.wa = wa; v.ld = ld; v.mq = mq; v.mr = mr;
    v.expEn = en; v.expFl = fl; v.expRs = fr; v.expRt = ft; v.expCnt = cnt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic setIn(input logic [4:0] rs, input logic [4:0] rt, input logic ur,
                       input logic ut, input logic br, input logic tk, input logic we,
                       input logic [4:0] wa, input logic ld, input logic mq, input logic mr);
    idRs = rs; idRt = rt; idUsesRs = ur; idUsesRt = ut; idIsBranch = br;
    idBranchTaken = tk; idWrEn = we; idWrAddr = wa; idIsLoad = ld;
    memReq = mq; memReady = mr;
  endtask

  function automatic logic [4:0] enVec();
    return {pcEn, ifidEn, idexEn, exmemEn, memwbEn};
  endfunction

  task automatic doReset();
    setIn(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_en", 32'(enVec()), 32'h1f);
    chk("reset_flush", 32'({ifidFlush, idexFlush}), 0);
    chk("reset_fwd", 32'({fwdRsSel, fwdRtSel}), 0);
    chk("reset_tmo", 32'(memTimeout), 0);
    chk("reset_cnt", 32'(stallCycles), 0);
    rst_n = 1'b1;
  endtask

  // Reference: sel is 1 + age of the youngest in-flight producer of the source.
  producer_t hist[$];

  function automatic int age(input logic [4:0] src, input logic uses);
    for (int k = 0; k < 3; k++)
      if (hist[k].we && hist[k].dst == src && src != 0 && uses) return k;
    return 3;
  endfunction

  vec_t vecs[14];

  initial begin
    #1;
    doReset();

    vecs[0]  = mk(0, 0, 0, 0, 0, 0, 1, 3, 0, 0, 1, 5'h1f, 2'b00, 0, 0, 0);
    vecs[1]  = mk(3, 0, 1, 0, 0, 0, 1, 4, 0, 0, 1, 5'h1f, 2'b00, 1, 0, 0);
    vecs[2]  = mk(3, 4, 1, 1, 0, 0, 0, 0, 0, 0, 1, 5'h1f, 2'b00, 2, 1, 0);
    vecs[3]  = mk(3, 4, 1, 1, 0, 0, 0, 0, 0, 0, 1, 5'h1f, 2'b00, 3, 2, 0);
    vecs[4]  = mk(3, 4, 1, 1, 0, 0, 1, 0, 0, 0, 1, 5'h1f, 2'b00, 0, 3, 0);
    vecs[5]  = mk(0, 0, 1, 1, 0, 0, 1, 0, 0, 0, 1, 5'h1f, 2'b00, 0, 0, 0);
    vecs[6]  = mk(0, 0, 0, 0, 0, 0, 1, 5, 1, 0, 1, 5'h1f, 2'b00, 0, 0, 0);
    vecs[7]  = mk(5, 0, 1, 0, 0, 0, 1, 6, 0, 0, 1, 5'h07, 2'b01, 1, 0, 0);
    vecs[8]  = mk(5, 0, 1, 0, 0, 0, 1, 6, 0, 0, 1, 5'h1f, 2'b00, 2, 0, 1);
    vecs[9]  = mk(7, 8, 1, 1, 1, 1, 0, 0, 0, 0, 1, 5'h1f, 2'b10, 0, 0, 1);
    vecs[10] = mk(0, 0, 0, 0, 0, 0, 1, 9, 0, 0, 1, 5'h1f, 2'b00, 0, 0, 1);
    vecs[11] = mk(9, 6, 1, 1, 1, 1, 0, 0, 0, 0, 1, 5'h07, 2'b01, 1, 3, 1);
    vecs[12] = mk(9, 6, 1, 1, 1, 1, 0, 0, 0, 0, 1, 5'h1f, 2'b10, 2, 0, 2);
    vecs[13] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 5'h1f, 2'b00, 0, 0, 2);

    for (int i = 0; i < 14; i++) begin
      setIn(vecs[i].rs, vecs[i].rt, vecs[i].ur, vecs[i].ut, vecs[i].br, vecs[i].tk,
            vecs[i].we, vecs[i].wa, vecs[i].ld, vecs[i].mq, vecs[i].mr);
      @(negedge clk);
      chk($sformatf("vec%0d_en", i), 32'(enVec()), 32'(vecs[i].expEn));
      chk($sformatf("vec%0d_flush", i), 32'({ifidFlush, idexFlush}), 32'(vecs[i].expFl));
      chk($sformatf("vec%0d_fwdrs", i), 32'(fwdRsSel), 32'(vecs[i].expRs));
      chk($sformatf("vec%0d_fwdrt", i), 32'(fwdRtSel), 32'(vecs[i].expRt));
      chk($sformatf("vec%0d_cnt", i), 32'(stallCycles), 32'(vecs[i].expCnt));
      @(posedge clk); #1;
    end

    // Freeze for 4 cycles with a taken jump held in ID: no advance, no flush.
    doReset();
    setIn(0, 0, 0, 0, 0, 0, 1, 3, 0, 0, 1);
    @(posedge clk); #1;
    for (int i = 1; i <= 4; i++) begin
      setIn(3, 0, 1, 0, 0, 1, 0, 0, 0, 1, 0);
      @(negedge clk);
      chk($sformatf("frz%0d_en", i), 32'(enVec()), 0);
      chk($sformatf("frz%0d_flush", i), 32'({ifidFlush, idexFlush}), 0);
      chk($sformatf("frz%0d_fwdrs", i), 32'(fwdRsSel), 1);
      chk($sformatf("frz%0d_cnt", i), 32'(stallCycles), 32'(i - 1));
      @(posedge clk); #1;
    end
    memReady = 1'b1;
    @(negedge clk);
    chk("frz_rel_en", 32'(enVec()), 32'h1f);
    chk("frz_rel_flush", 32'({ifidFlush, idexFlush}), 32'b10);
    chk("frz_rel_fwdrs", 32'(fwdRsSel), 1);
    chk("frz_rel_cnt", 32'(stallCycles), 4);
    chk("frz_rel_tmo", 32'(memTimeout), 0);
    @(posedge clk); #1;

    // Timeout after 8 wait cycles, sticky through ready, cleared by async reset mid-wait.
    doReset();
    for (int i = 1; i <= 10; i++) begin
      setIn(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      @(negedge clk);
      chk($sformatf("tmo%0d", i), 32'(memTimeout), 32'(i >= 9));
      @(posedge clk); #1;
    end
    memReady = 1'b1;
    @(negedge clk);
    chk("tmo_ready_en", 32'(enVec()), 32'h1f);
    chk("tmo_ready_flag", 32'(memTimeout), 1);
    chk("tmo_ready_cnt", 32'(stallCycles), 10);
    @(posedge clk); #1;
    memReady = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("tmo_rewait_flag", 32'(memTimeout), 1);
    rst_n = 1'b0;
    #1;
    chk("tmo_rst_flag", 32'(memTimeout), 0);
    chk("tmo_rst_cnt", 32'(stallCycles), 0);
    memReq = 1'b0;
    memReady = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("tmo_rst_en", 32'(enVec()), 32'h1f);
    @(posedge clk); #1;

    // Randomized traffic against the producer-age model.
    doReset();
    begin
      int cnt = 0;
      int run = 0;
      bit waiting = 0;
      bit tmo = 0;
      hist = {};
      for (int k = 0; k < 3; k++) hist.push_back('{we: 1'b0, dst: 5'd0, ld: 1'b0});
      for (int n = 0; n < 600; n++) begin
        int aRs, aRt;
        bit frz, lu, bs, stall;
        logic [4:0] eEn;
        logic [1:0] eFl;
        setIn(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 1'($urandom),
              1'($urandom), 1'($urandom_range(0, 3) == 0), 1'($urandom), 1'($urandom),
              5'($urandom_range(0, 7)), 1'($urandom_range(0, 2) == 0),
              1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 2) != 0));
        aRs = age(idRs, idUsesRs);
        aRt = age(idRt, idUsesRt);
        frz = memReq && !memReady;
        lu = (aRs == 0 && hist[0].ld) || (aRt == 0 && hist[0].ld);
        bs = idIsBranch && (aRs == 0 || aRt == 0);
        stall = !frz && (lu || bs);
        eEn = frz ? 5'h00 : (stall ? 5'h07 : 5'h1f);
        eFl = frz ? 2'b00 : (stall ? 2'b01 : {idBranchTaken, 1'b0});
        @(negedge clk);
        chk("rnd_en", 32'(enVec()), 32'(eEn));
        chk("rnd_flush", 32'({ifidFlush, idexFlush}), 32'(eFl));
        chk("rnd_fwdrs", 32'(fwdRsSel), 32'(aRs < 3 ? aRs + 1 : 0));
        chk("rnd_fwdrt", 32'(fwdRtSel), 32'(aRt < 3 ? aRt + 1 : 0));
        chk("rnd_cnt", 32'(stallCycles), 32'(cnt));
        chk("rnd_tmo", 32'(memTimeout), 32'(tmo));
        @(posedge clk);
        if (!frz) begin
          hist.push_front('{we: idWrEn && idWrAddr != 0 && !stall, dst: idWrAddr,
                            ld: idIsLoad});
          void'(hist.pop_back());
        end
        if (frz || stall) cnt++;
        if (!memReady && (waiting || memReq)) begin
          waiting = 1;
          run++;
          if (run >= 8) tmo = 1;
        end else begin
          waiting = 0;
          run = 0;
        end
        #1;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

endmodule
